// File: rtl/loopback_test_pkg.sv
// Shared types and constants for the fiber-link loopback test sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: run-state enum, 128-bit pattern seed (word 0) and per-lane step.
package loopback_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lb_state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;

  // Word 0: lane i holds i+1.
  localparam logic [127:0] PATTERN_SEED = {32'h0000_0004, 32'h0000_0003,
                                           32'h0000_0002, 32'h0000_0001};
  // Every lane advances by 4 per word, independently of its neighbours.
  localparam logic [127:0] PATTERN_STEP = {4{32'h0000_0004}};

endpackage

// File: rtl/pattern_gen.sv
// Incrementing test-pattern generator: four independent 32-bit lanes.
// Latency: word reflects load/adv one cycle after the edge that samples them.
// Backpressure: none; the caller advances it only on accepted/received beats.
// Ports: clk_usr, rst (async, high) | load -> seed, adv -> +step per lane | word out.
module pattern_gen
  import loopback_test_pkg::*;
#(
  parameter logic [127:0] SEED = PATTERN_SEED
) (
  input  logic         clk_usr,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  output logic [127:0] word
);

  logic [127:0] word_q;

  // Per-lane add: a carry out of one lane is dropped, never propagated.
  always_ff @(posedge clk_usr or posedge rst) begin
    if (rst) begin
      word_q <= SEED;
    end else if (load) begin
      word_q <= SEED;
    end else if (adv) begin
      for (int i = 0; i < LANES; i++) begin
        word_q[i*LANE_W +: LANE_W] <= word_q[i*LANE_W +: LANE_W]
                                      + PATTERN_STEP[i*LANE_W +: LANE_W];
      end
    end
  end

  assign word = word_q;

endmodule

// File: rtl/loopback_test_ctrl.sv
// Loopback test sequencer: sends num_words pattern words, checks the returned stream.
// Latency: tx_valid one cycle after start is sampled; done one cycle after final RX beat.
// Backpressure: TX honours tx_ready (data held while stalled); RX has none (every beat counted).
// Ports: start/abort/num_words from host | tx_data/tx_valid/tx_ready to link |
//        rx_data/rx_valid from link | busy/done/pass/timeout/rx_cnt/err_cnt/first_err_idx to host.
module loopback_test_ctrl
  import loopback_test_pkg::*;
#(
  parameter int           TIMEOUT = 1024,
  parameter int           CNT_W   = 32,
  parameter logic [127:0] SEED    = PATTERN_SEED
) (
  input  logic             clk_usr,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_words,
  output logic [127:0]     tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [127:0]     rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int IDLE_W = $clog2(TIMEOUT);

  lb_state_t          state, state_nxt;
  logic [CNT_W-1:0]   num_q, sent_cnt;
  logic [CNT_W-1:0]   sent_nxt, rx_cnt_nxt, err_cnt_nxt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [127:0]       rx_exp;
  logic               in_run, start_run, tx_fire, rx_fire, rx_mismatch;
  logic               all_done, to_hit;

  pattern_gen #(.SEED(SEED)) u_tx_gen (
    .clk_usr (clk_usr),
    .rst     (rst),
    .load    (start_run),
    .adv     (tx_fire),
    .word    (tx_data)
  );

  pattern_gen #(.SEED(SEED)) u_rx_gen (
    .clk_usr (clk_usr),
    .rst     (rst),
    .load    (start_run),
    .adv     (rx_fire),
    .word    (rx_exp)
  );

  always_comb begin
    in_run      = (state == ST_SEND) || (state == ST_DRAIN);
    start_run   = (state == ST_IDLE) && start;
    tx_fire     = tx_valid && tx_ready;
    // An aborted edge leaves the counts exactly as they were.
    rx_fire     = in_run && rx_valid && !abort;
    rx_mismatch = rx_fire && (rx_data != rx_exp);
    sent_nxt    = sent_cnt + CNT_W'(tx_fire);
    rx_cnt_nxt  = rx_cnt + CNT_W'(rx_fire);
    err_cnt_nxt = (rx_mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
    all_done    = (sent_nxt == num_q) && (rx_cnt_nxt >= num_q);
    // Completion on the same edge wins over the idle timer.
    to_hit      = in_run && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1)) && !all_done;

    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_words == '0) ? ST_DONE : ST_SEND;
      end
      ST_SEND, ST_DRAIN: begin
        if (abort)                                   state_nxt = ST_IDLE;
        else if (all_done || to_hit)                 state_nxt = ST_DONE;
        else if (state == ST_SEND && sent_nxt == num_q) state_nxt = ST_DRAIN;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_usr or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_usr or posedge rst) begin
    if (rst) begin
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      num_q         <= '0;
      sent_cnt      <= '0;
      rx_cnt        <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      idle_cnt      <= '0;
    end else begin
      // tx_valid is high exactly while words remain to be sent.
      tx_valid <= (state_nxt == ST_SEND);
      busy     <= (state_nxt == ST_SEND) || (state_nxt == ST_DRAIN);
      done     <= (state_nxt == ST_DONE);

      if (start_run) begin
        num_q         <= num_words;
        sent_cnt      <= '0;
        rx_cnt        <= '0;
        err_cnt       <= '0;
        first_err_idx <= '1;
        timeout       <= 1'b0;
        idle_cnt      <= '0;
        pass          <= (num_words == '0);
      end else if (in_run) begin
        if (abort) begin
          pass <= 1'b0;
        end else begin
          sent_cnt <= sent_nxt;
          rx_cnt   <= rx_cnt_nxt;
          err_cnt  <= err_cnt_nxt;
          // err_cnt saturates and never returns to zero, so zero marks "no mismatch yet".
          if (rx_mismatch && (err_cnt == '0)) first_err_idx <= rx_cnt;
          idle_cnt <= rx_valid ? '0 : idle_cnt + 1'b1;
          if (state_nxt == ST_DONE) begin
            pass    <= (err_cnt_nxt == '0) && !to_hit;
            timeout <= to_hit;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_loopback_test_ctrl.sv
// Self-checking bench for loopback_test_ctrl: randomized loopback runs vs. a pattern model.
// Latency: n/a.
// Backpressure: tx_ready driven randomly in some runs.
module tb_loopback_test_ctrl;

  localparam int TMO = 32;
  localparam logic [127:0] WRAP_SEED = {32'h0000_0004, 32'h0000_0003,
                                        32'h0000_0002, 32'hFFFF_FFFD};

  logic         clk_usr = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, abort = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0]  num_words = '0;
  logic [127:0] rx_data = '0;
  logic [127:0] tx_data;
  logic         tx_valid, busy, done, pass, timeout;
  logic [31:0]  rx_cnt, err_cnt, first_err_idx;

  // Second instance seeded near the lane wrap point, looped back combinationally.
  logic         start_w = 1'b0, tx_ready_w = 1'b1;
  logic [31:0]  num_w = '0;
  logic [127:0] tx_data_w;
  logic         tx_valid_w, busy_w, done_w, pass_w, timeout_w;
  logic [31:0]  rx_cnt_w, err_cnt_w, first_w;
  wire          rx_valid_w = tx_valid_w & tx_ready_w;
  wire  [127:0] rx_data_w  = tx_data_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [127:0] seed0 = {32'd4, 32'd3, 32'd2, 32'd1};
  logic [127:0] seedw = WRAP_SEED;

  always #5 clk_usr = ~clk_usr;

  loopback_test_ctrl #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk_usr(clk_usr), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .rx_cnt(rx_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  loopback_test_ctrl #(.TIMEOUT(TMO), .CNT_W(32), .SEED(WRAP_SEED)) dut_w (
    .clk_usr(clk_usr), .rst(rst), .start(start_w), .abort(1'b0), .num_words(num_w),
    .tx_data(tx_data_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready_w),
    .rx_data(rx_data_w), .rx_valid(rx_valid_w),
    .busy(busy_w), .done(done_w), .pass(pass_w), .timeout(timeout_w),
    .rx_cnt(rx_cnt_w), .err_cnt(err_cnt_w), .first_err_idx(first_w)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference pattern: lane i of word k = seed lane i + 4k, modulo 2^32 per lane.
  function automatic logic [127:0] pat(input logic [127:0] seed, input int k);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[32*i +: 32] = seed[32*i +: 32] + 32'(4 * k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_usr);
    cyc++;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txv"},   128'(tx_valid), 128'(0));
    chk({tag, "_txd"},   tx_data, pat(seed0, 0));
    chk({tag, "_busy"},  128'(busy), 128'(0));
    chk({tag, "_done"},  128'(done), 128'(0));
    chk({tag, "_pass"},  128'(pass), 128'(0));
    chk({tag, "_tmo"},   128'(timeout), 128'(0));
    chk({tag, "_rxc"},   128'(rx_cnt), 128'(0));
    chk({tag, "_errc"},  128'(err_cnt), 128'(0));
    chk({tag, "_first"}, 128'(first_err_idx), 128'(32'hFFFF_FFFF));
  endtask

  // mode 0: run to completion; 1: abort once in DRAIN; 2: async reset mid-SEND.
  task automatic run(input int n, input int rdy_pct, input int bad_idx,
                     input int stop_after, input int mode, input string tag);
    int sent = 0, got = 0, errs = 0;
    int start_edge, last_beat_edge = -1, done_edge = -1;
    logic [31:0]  first = '1;
    logic [127:0] mask, pend_d, prev_d, exp_w;
    logic pend_v = 1'b0, prev_stall = 1'b0;
    bit exp_to;
    mask = 128'h1 << 64;
    pend_d = '0;
    prev_d = '0;
    exp_to = (stop_after >= 0);
    start = 1'b1;
    num_words = 32'(n);
    tick();
    start = 1'b0;
    start_edge = cyc;
    while (cyc - start_edge < 3000) begin
      if (done) begin
        done_edge = cyc;
        break;
      end
      if (prev_stall) chk({tag, "_hold"}, tx_data, prev_d);
      if (mode == 1 && busy && !tx_valid && sent == n) begin
        rx_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_pass"}, 128'(pass), 128'(0));
        chk({tag, "_txv"},  128'(tx_valid), 128'(0));
        chk({tag, "_rxc"},  128'(rx_cnt), 128'(got));
        // Beats arriving in IDLE must be ignored and no late done may appear.
        rx_valid = 1'b1;
        rx_data = '0;
        repeat (3) begin
          tick();
          chk({tag, "_nodone"}, 128'(done), 128'(0));
          chk({tag, "_frozen"}, 128'(rx_cnt), 128'(got));
        end
        rx_valid = 1'b0;
        return;
      end
      if (mode == 2 && cyc - start_edge == 10) begin
        chk({tag, "_busy_pre"}, 128'(busy), 128'(1));
        rx_valid = 1'b0;
        #3 rst = 1'b1;
        #1 chk_reset_vals(tag);
        return;
      end
      rx_valid = pend_v;
      rx_data = pend_d;
      if (pend_v) begin
        if (pend_d != pat(seed0, got)) begin
          errs++;
          if (first == '1) first = 32'(got);
        end
        got++;
        last_beat_edge = cyc + 1;
      end
      tx_ready = ($urandom_range(99) < rdy_pct);
      pend_v = 1'b0;
      if (tx_valid && tx_ready) begin
        exp_w = pat(seed0, sent);
        chk({tag, "_txword"}, tx_data, exp_w);
        if (stop_after < 0 || sent < stop_after) begin
          pend_v = 1'b1;
          pend_d = (sent == bad_idx) ? (tx_data ^ mask) : tx_data;
        end
        sent++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
      tick();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk({tag, "_done_seen"}, 128'(done_edge >= 0), 128'(1));
    chk({tag, "_sent"},  128'(sent), 128'(n));
    chk({tag, "_rxc"},   128'(rx_cnt), 128'(got));
    chk({tag, "_errc"},  128'(err_cnt), 128'(errs));
    chk({tag, "_first"}, 128'(first_err_idx), 128'(first));
    chk({tag, "_pass"},  128'(pass), 128'(errs == 0 && !exp_to));
    chk({tag, "_tmo"},   128'(timeout), 128'(exp_to));
    chk({tag, "_busy"},  128'(busy), 128'(0));
    chk({tag, "_txv"},   128'(tx_valid), 128'(0));
    if (exp_to)
      chk({tag, "_tmo_cyc"}, 128'(done_edge), 128'(last_beat_edge + TMO));
    else
      chk({tag, "_done_cyc"}, 128'(done_edge), 128'(last_beat_edge));
    if (rdy_pct == 100 && !exp_to)
      chk({tag, "_done_abs"}, 128'(done_edge), 128'(start_edge + n + 1));
    tick();
    chk({tag, "_pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    int k;
    repeat (3) tick();
    chk_reset_vals("rst0");
    rst = 1'b0;
    tick();

    run(16, 100, -1, -1, 0, "loop16");
    run(16, 100,  5, -1, 0, "bad5");
    run(100, 50, -1, -1, 0, "rand100");
    run(20, 100, -1, 10, 0, "tmo");

    // Zero-length run: immediate done, pass, no TX.
    start = 1'b1;
    num_words = '0;
    tick();
    start = 1'b0;
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_pass", 128'(pass), 128'(1));
    chk("zero_txv",  128'(tx_valid), 128'(0));
    chk("zero_busy", 128'(busy), 128'(0));
    tick();
    chk("zero_pulse", 128'(done), 128'(0));
    chk("zero_txv2",  128'(tx_valid), 128'(0));

    run(8, 100, -1, 4, 1, "abort");
    run(50, 100, -1, -1, 2, "midrst");
    tick();
    rst = 1'b0;
    tick();

    // Lane wrap: FFFF_FFFD + 4 -> 1 with no carry into lane 1.
    start_w = 1'b1;
    num_w = 32'd4;
    tick();
    start_w = 1'b0;
    k = 0;
    for (int c = 0; c < 50; c++) begin
      if (done_w) break;
      if (tx_valid_w) begin
        chk("wrap_word", tx_data_w, pat(seedw, k));
        if (k == 1) begin
          chk("wrap_l0", 128'(tx_data_w[31:0]), 128'(32'h1));
          chk("wrap_l1", 128'(tx_data_w[63:32]), 128'(32'h6));
        end
        k++;
      end
      tick();
    end
    chk("wrap_done", 128'(done_w), 128'(1));
    chk("wrap_cnt",  128'(k), 128'(4));
    chk("wrap_rxc",  128'(rx_cnt_w), 128'(4));
    chk("wrap_errc", 128'(err_cnt_w), 128'(0));
    chk("wrap_pass", 128'(pass_w), 128'(1));
    chk("wrap_first", 128'(first_w), 128'(32'hFFFF_FFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loopback_test_ctrl.md
# loopback_test_ctrl

Sequencer for the 128-bit fiber-link loopback test. On `start` it generates a bounded stream of 4×32-bit incrementing test words toward the link TX user interface. It checks every word returned on the RX user interface against an independent expected-pattern generator. It reports per-run word and error counts, the index of the first mismatching word, a timeout flag and a pass/fail verdict to the host register block. It sits between the PCIe-side control registers and the fiber link user ports, in the `clk_usr` domain.

## Interface
- `TIMEOUT`, 1024: RX-idle cycles tolerated in SEND/DRAIN before the run is declared timed out (≥2).
- `CNT_W`, 32: width of word/error counters and `num_words`.
- `clk_usr` in 1: user clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: level sampled in IDLE; starts a run.
- `abort` in 1: cancels a run in progress.
- `num_words` in CNT_W: words per run; sampled on the start edge.
- `tx_data` out 128: test word to the link.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: link accepts a word when `tx_valid && tx_ready`.
- `rx_data` in 128: looped-back word.
- `rx_valid` in 1: `rx_data` valid; no backpressure.
- `busy` out 1: run in progress (SEND or DRAIN).
- `done` out 1: one-cycle pulse at run end.
- `pass` out 1: verdict, held until the next start.
- `timeout` out 1: last run ended by timeout, held.
- `rx_cnt` out CNT_W: words received this run.
- `err_cnt` out CNT_W: mismatching words this run; saturates at all-ones.
- `first_err_idx` out CNT_W: rx index of the first mismatch; all-ones if none.

## Operation
- Pattern word k (k from 0): lane i (bits 32i+31:32i) = 4k+i+1 mod 2^32. Word 0 = 0000_0004_0000_0003_0000_0002_0000_0001; each next word adds 4 to every lane, wrapping per lane with no carry between lanes.
- States:
  - IDLE: `busy`=0, results held.
  - SEND: TX active, RX checking.
  - DRAIN: all words sent, waiting for RX.
  - DONE: one cycle, `done`=1, then IDLE.
- IDLE→SEND when `start`=1 and `num_words`≠0. This edge:
  - clears `rx_cnt`, `err_cnt` and `timeout`;
  - sets `first_err_idx` to all-ones and `pass` to 0;
  - loads both generators with word 0.
- IDLE→DONE when `start`=1 and `num_words`=0: no TX, `pass`=1.
- TX: on each handshake, advance the TX generator and the sent count. When sent = `num_words`, deassert `tx_valid`; go to DRAIN if rx_cnt < num_words after this edge, otherwise DONE.
- RX: each `rx_valid` in SEND/DRAIN does the following:
  - compares `rx_data` with the RX generator output;
  - increments `rx_cnt`;
  - on mismatch, increments `err_cnt` (saturating) and, if this is the first mismatch, latches `first_err_idx` = current rx index;
  - always advances the RX generator (no resync).
- RX may run ahead of TX; the two sides are counted independently.
- SEND/DRAIN→DONE on the edge where both sent = `num_words` and rx_cnt reaches `num_words`.
- `rx_valid` in IDLE/DONE is ignored.
- Timeout: in SEND/DRAIN, `TIMEOUT` consecutive cycles without `rx_valid` set `timeout`=1 and go to DONE. The idle counter clears on every `rx_valid` and on start.
- On entering DONE, `pass` = (`err_cnt`=0 including the final beat) and not `timeout`.
- `abort` in SEND/DRAIN → IDLE next edge: `tx_valid`=0, no `done`, `pass`=0, counts frozen. `abort` has priority over the completion and timeout transitions on the same edge.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `tx_valid`=0, `tx_data`=word 0;
  - `busy`=`done`=`pass`=`timeout`=0;
  - `rx_cnt`=`err_cnt`=0, `first_err_idx`=all-ones.
- `tx_valid` rises on the first edge after start is sampled. All outputs are registered.
- `tx_data` is stable while `tx_valid && !tx_ready`. After an accepted word, the next word is presented on the following cycle, so full throughput is one word per cycle.
- An RX beat sampled at edge n is reflected in `rx_cnt`/`err_cnt` after edge n.
- `done` is high in the cycle after the final RX beat, with final counts and `pass` already valid.
- Reset mid-run: all outputs return to reset values immediately (asynchronous).

## Structure
- Package `loopback_test_pkg`: state enum (IDLE, SEND, DRAIN, DONE), `PATTERN_SEED` = word 0, `PATTERN_STEP` = 0000_0004 ×4.
- Sub-module `pattern_gen`: 128-bit, four 32-bit lanes, with `load` (to seed) and `adv` (+step). It is instantiated twice, once for TX and once for RX expected.

## Test plan
- Loopback (tx→rx, one-cycle delay, `tx_ready`=1), `num_words`=16 → 16 words with lane0 = 1,5,…,61; `done` at the expected cycle; `rx_cnt`=16, `err_cnt`=0, `pass`=1, `first_err_idx`=FFFF_FFFF.
- Same run with word 5 lane2 XOR 1 on RX → `err_cnt`=1, `first_err_idx`=5, `pass`=0. Word 6 is still checked correctly (no resync).
- `tx_ready` toggled randomly, `num_words`=100 → `tx_data` held during stalls, all 100 words in order, `pass`=1.
- RX stopped after 10 of 20 words → `timeout`=1 exactly `TIMEOUT` cycles after the last beat, `done` pulse, `pass`=0, `rx_cnt`=10.
- Edge cases:
  - `num_words`=0 → `done` one cycle after start, `pass`=1, no `tx_valid`.
  - `abort` in DRAIN → IDLE, no `done`.
  - `rst` mid-SEND → all outputs return to reset values.
- Wrap: force the generator seed near the wrap point (lane0 = FFFF_FFFD) → next lane0 = 0000_0001, with no carry into lane1 and no false error.
